vram_write_arbiter: RTL and testbench

Shares the single write port (port A) of the 70×30 character video RAM among three requesters: the border/status-line painter, the falling-character renderer and the cell-clear path. The arbiter grants one write per cycle round-robin, range-checks every address against the screen size and runs an internal full-screen clear sequence on command. It sits between the game-logic writers and `video_ram` port A; `wr_en`, `wr_addr` and `wr_data` drive `wren_a`, `address_a` and `data_a` directly.

---
 rtl/vram_write_arbiter.sv | 143 ++++++++++++++
 tb/tb_vram_write_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/vram_write_arbiter.sv
// rtl/vram_write_arbiter.sv - round-robin write-port arbiter for the character video RAM with full-screen clear
module vram_write_arbiter #(
  parameter int ADDR_W       = 12,
  parameter int DATA_W       = 8,
  parameter int SCREEN_CELLS = 2100
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [2:0]        req_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [ADDR_W-1:0] addr2_i,
  input  logic [DATA_W-1:0] data0_i,
  input  logic [DATA_W-1:0] data1_i,
  input  logic [DATA_W-1:0] data2_i,
  output logic [2:0]        gnt_o,
  input  logic              clr_start_i,
  output logic              clr_busy_o,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [DATA_W-1:0] wr_data_o,
  output logic [7:0]        drop_cnt_o
);

  localparam int                CNT_W     = $clog2(SCREEN_CELLS);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SCREEN_CELLS - 1);
  localparam logic [ADDR_W:0]   CELLS_LIM = (ADDR_W + 1)'(SCREEN_CELLS);

  typedef enum logic {ST_ARB, ST_CLEAR} state_t;

  state_t            state_q;
  logic [1:0]        ptr_q;
  logic [CNT_W-1:0]  clr_cnt_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic [7:0]        drop_cnt_q;

  logic [1:0]        p0, p1, p2;
  logic [1:0]        win_d;
  logic              any_d;
  logic              arb_ok;
  logic [2:0]        gnt_d;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  // Search order starts one past the last granted requester and wraps
  always_comb begin
    p0 = 2'd0;
    p1 = 2'd1;
    p2 = 2'd2;
    case (ptr_q)
      2'd0:    begin p0 = 2'd1; p1 = 2'd2; p2 = 2'd0; end
      2'd1:    begin p0 = 2'd2; p1 = 2'd0; p2 = 2'd1; end
      default: begin p0 = 2'd0; p1 = 2'd1; p2 = 2'd2; end
    endcase
  end

  // Pick the winner; clear and reset both suppress any grant
  always_comb begin
    win_d  = p0;
    any_d  = 1'b0;
    gnt_d  = 3'b000;
    arb_ok = (state_q == ST_ARB) && !clr_start_i && !rst_i;
    if (req_i[p0]) begin
      win_d = p0; any_d = 1'b1;
    end else if (req_i[p1]) begin
      win_d = p1; any_d = 1'b1;
    end else if (req_i[p2]) begin
      win_d = p2; any_d = 1'b1;
    end
    if (arb_ok && any_d) begin
      gnt_d[win_d] = 1'b1;
    end
  end

  // Route the winner's address and data toward the write registers
  always_comb begin
    sel_addr = addr0_i;
    sel_data = data0_i;
    case (win_d)
      2'd1:    begin sel_addr = addr1_i; sel_data = data1_i; end
      2'd2:    begin sel_addr = addr2_i; sel_data = data2_i; end
      default: begin sel_addr = addr0_i; sel_data = data0_i; end
    endcase
  end

  // Arbitration / clear state machine with registered port-A outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_ARB;
      ptr_q      <= 2'd2;
      clr_cnt_q  <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      drop_cnt_q <= 8'd0;
    end else begin
      case (state_q)
        ST_ARB: begin
          if (clr_start_i) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
            wr_en_q   <= 1'b0;
          end else if (|gnt_d) begin
            ptr_q <= win_d;
            if ({1'b0, sel_addr} < CELLS_LIM) begin
              wr_en_q   <= 1'b1;
              wr_addr_q <= sel_addr;
              wr_data_q <= sel_data;
            end else begin
              // Off-screen writes are consumed so the requester is not stuck
              wr_en_q <= 1'b0;
              if (drop_cnt_q != 8'hFF) begin
                drop_cnt_q <= drop_cnt_q + 8'd1;
              end
            end
          end else begin
            wr_en_q <= 1'b0;
          end
        end
        ST_CLEAR: begin
          wr_en_q   <= 1'b1;
          wr_addr_q <= ADDR_W'(clr_cnt_q);
          wr_data_q <= '0;
          if (clr_cnt_q == CNT_LAST) begin
            state_q <= ST_ARB;
          end else begin
            clr_cnt_q <= clr_cnt_q + 1'b1;
          end
        end
      endcase
    end
  end

  assign gnt_o      = gnt_d;
  assign clr_busy_o = (state_q == ST_CLEAR);
  assign wr_en_o    = wr_en_q;
  assign wr_addr_o  = wr_addr_q;
  assign wr_data_o  = wr_data_q;
  assign drop_cnt_o = drop_cnt_q;

endmodule

// File: tb/tb_vram_write_arbiter.sv
// tb/tb_vram_write_arbiter.sv - self-checking bench for vram_write_arbiter
module tb_vram_write_arbiter;

  localparam int CELLS = 2100;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  req = 3'b000;
  logic [11:0] addr0 = '0, addr1 = '0, addr2 = '0;
  logic [7:0]  data0 = '0, data1 = '0, data2 = '0;
  logic [2:0]  gnt;
  logic        clr_start = 1'b0;
  logic        clr_busy;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [7:0]  wr_data;
  logic [7:0]  drop_cnt;

  always #5 clk = ~clk;

  vram_write_arbiter dut (
    .clk_i(clk), .rst_i(rst), .req_i(req),
    .addr0_i(addr0), .addr1_i(addr1), .addr2_i(addr2),
    .data0_i(data0), .data1_i(data1), .data2_i(data2),
    .gnt_o(gnt), .clr_start_i(clr_start), .clr_busy_o(clr_busy),
    .wr_en_o(wr_en), .wr_addr_o(wr_addr), .wr_data_o(wr_data),
    .drop_cnt_o(drop_cnt)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: last granted index, clear progress, drop count, expected write
  int m_last, m_clr_left, m_clr_addr, m_drop;
  bit m_wen;
  int m_waddr, m_wdata;
  bit busy_seen;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic m_reset();
    m_last = 2; m_clr_left = 0; m_clr_addr = 0; m_drop = 0;
    m_wen = 0; m_waddr = 0; m_wdata = 0;
  endtask

  // One clock: drive at edge+1, check gnt before the edge, check writes at edge+1
  task automatic cycle(input logic [2:0] r, input int a0, input int a1, input int a2,
                       input int d0, input int d1, input int d2, input bit clr,
                       output logic [2:0] g);
    int ad[3];
    int dt[3];
    int win;
    logic [2:0] eg;
    bit ebusy;
    ad = '{a0, a1, a2};
    dt = '{d0, d1, d2};
    req = r; addr0 = a0[11:0]; addr1 = a1[11:0]; addr2 = a2[11:0];
    data0 = d0[7:0]; data1 = d1[7:0]; data2 = d2[7:0];
    clr_start = clr;
    ebusy = (m_clr_left > 0);
    eg = 3'b000;
    win = -1;
    if (!ebusy && !clr) begin
      for (int k = 1; k <= 3; k++) begin
        int c;
        c = (m_last + k) % 3;
        if (win < 0 && r[c]) win = c;
      end
    end
    if (win >= 0) eg[win] = 1'b1;
    #3;
    g = gnt;
    busy_seen = clr_busy;
    chk("gnt", {29'd0, gnt}, {29'd0, eg});
    chk("clr_busy", {31'd0, clr_busy}, {31'd0, ebusy});
    if (ebusy) begin
      m_wen = 1; m_waddr = m_clr_addr; m_wdata = 0;
      m_clr_addr++; m_clr_left--;
    end else if (clr) begin
      m_wen = 0; m_clr_left = CELLS; m_clr_addr = 0;
    end else if (win >= 0) begin
      m_last = win;
      if (ad[win] < CELLS) begin
        m_wen = 1; m_waddr = ad[win]; m_wdata = dt[win];
      end else begin
        m_wen = 0;
        if (m_drop < 255) m_drop++;
      end
    end else begin
      m_wen = 0;
    end
    @(posedge clk);
    #1;
    clr_start = 1'b0;
    chk("wr_en", {31'd0, wr_en}, {31'd0, m_wen});
    if (m_wen) begin
      chk("wr_addr", {20'd0, wr_addr}, m_waddr);
      chk("wr_data", {24'd0, wr_data}, m_wdata);
    end
    chk("drop_cnt", {24'd0, drop_cnt}, m_drop);
  endtask

  typedef struct {
    logic [2:0] req;
    int a0, a1, a2, d;
    logic [2:0] egnt;
    bit ewen;
    int eaddr, edata, edrop;
  } vec_t;

  vec_t tbl[$];

  initial begin
    logic [2:0] g;
    int busy_cnt, first_g2, gap, max_gap;

    tbl.push_back('{3'b111,   71,   72,   73, 42, 3'b001, 1'b1,   71, 42, 0});
    tbl.push_back('{3'b111,   71,   72,   73, 42, 3'b010, 1'b1,   72, 42, 0});
    tbl.push_back('{3'b111,   71,   72,   73, 42, 3'b100, 1'b1,   73, 42, 0});
    tbl.push_back('{3'b111,   71,   72,   73, 42, 3'b001, 1'b1,   71, 42, 0});
    tbl.push_back('{3'b010,    0, 2099,    0, 65, 3'b010, 1'b1, 2099, 65, 0});
    tbl.push_back('{3'b010,    0, 2100,    0, 66, 3'b010, 1'b0,    0,  0, 1});
    tbl.push_back('{3'b000,    0,    0,    0,  0, 3'b000, 1'b0,    0,  0, 1});
    tbl.push_back('{3'b101,    5,    0,    7,  3, 3'b100, 1'b1,    7,  3, 1});
    tbl.push_back('{3'b101,    5,    0,    7,  3, 3'b001, 1'b1,    5,  3, 1});
    tbl.push_back('{3'b100,    0,    0, 4095,  1, 3'b100, 1'b0,    0,  0, 2});
    tbl.push_back('{3'b011,   10,   11,    0,  8, 3'b001, 1'b1,   10,  8, 2});
    tbl.push_back('{3'b011,   10,   11,    0,  8, 3'b010, 1'b1,   11,  8, 2});

    // Asynchronous reset with requests present
    m_reset();
    req = 3'b111;
    #1 rst = 1'b1;
    #1;
    chk("rst_gnt", {29'd0, gnt}, 32'd0);
    chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
    chk("rst_wr_addr", {20'd0, wr_addr}, 32'd0);
    chk("rst_wr_data", {24'd0, wr_data}, 32'd0);
    chk("rst_drop", {24'd0, drop_cnt}, 32'd0);
    chk("rst_busy", {31'd0, clr_busy}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Table vectors
    foreach (tbl[i]) begin
      cycle(tbl[i].req, tbl[i].a0, tbl[i].a1, tbl[i].a2, tbl[i].d, tbl[i].d, tbl[i].d, 1'b0, g);
      chk("tbl_gnt", {29'd0, g}, {29'd0, tbl[i].egnt});
      chk("tbl_wr_en", {31'd0, wr_en}, {31'd0, tbl[i].ewen});
      if (tbl[i].ewen) begin
        chk("tbl_wr_addr", {20'd0, wr_addr}, tbl[i].eaddr);
        chk("tbl_wr_data", {24'd0, wr_data}, tbl[i].edata);
      end
      chk("tbl_drop", {24'd0, drop_cnt}, tbl[i].edrop);
    end

    // Drop counter saturation
    for (int i = 0; i < 300; i++) cycle(3'b010, 0, 2100 + (i % 1000), 0, 0, 1, 0, 1'b0, g);
    chk("drop_sat", {24'd0, drop_cnt}, 32'd255);

    // Clear with a simultaneous request, plus an ignored second clr_start
    cycle(3'b001, 300, 0, 0, 9, 0, 0, 1'b1, g);
    chk("clr_no_gnt", {29'd0, g}, 32'd0);
    busy_cnt = 0;
    for (int i = 1; i <= CELLS; i++) begin
      cycle(3'b001, 300, 0, 0, 9, 0, 0, (i == 500), g);
      if (busy_seen) busy_cnt++;
      if (i == 1)    chk("clr_first_addr", {20'd0, wr_addr}, 32'd0);
      if (i == 501)  chk("clr_no_restart", {20'd0, wr_addr}, 32'd500);
      if (i == CELLS) begin
        chk("clr_last_addr", {20'd0, wr_addr}, CELLS - 1);
        chk("clr_done_busy", {31'd0, clr_busy}, 32'd0);
      end
    end
    chk("clr_busy_cycles", busy_cnt, CELLS);
    cycle(3'b001, 300, 0, 0, 9, 0, 0, 1'b0, g);
    chk("post_clr_gnt", {29'd0, g}, 32'd1);
    chk("post_clr_addr", {20'd0, wr_addr}, 32'd300);
    chk("post_clr_data", {24'd0, wr_data}, 32'd9);

    // Reset in the middle of a clear
    cycle(3'b000, 0, 0, 0, 0, 0, 0, 1'b1, g);
    for (int i = 1; i <= 1000; i++) cycle(3'b000, 0, 0, 0, 0, 0, 0, 1'b0, g);
    req = 3'b111;
    #1 rst = 1'b1;
    #1;
    chk("midclr_wr_en", {31'd0, wr_en}, 32'd0);
    chk("midclr_busy", {31'd0, clr_busy}, 32'd0);
    chk("midclr_drop", {24'd0, drop_cnt}, 32'd0);
    chk("midclr_gnt", {29'd0, gnt}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    m_reset();
    cycle(3'b111, 1, 2, 3, 4, 5, 6, 1'b0, g);
    chk("post_rst_first", {29'd0, g}, 32'd1);

    // Requester 2 held while requester 0 toggles
    first_g2 = -1; gap = 0; max_gap = 0;
    for (int i = 0; i < 12; i++) begin
      cycle({1'b1, 1'b0, ~i[0]}, 20, 0, 22, 1, 0, 2, 1'b0, g);
      if (g[2]) begin
        if (first_g2 < 0) first_g2 = i;
        gap = 0;
      end else begin
        gap++;
        if (gap > max_gap) max_gap = gap;
      end
    end
    chk("fair_first_g2", {31'd0, (first_g2 >= 0 && first_g2 <= 2)}, 32'd1);
    chk("fair_max_gap", {31'd0, (max_gap <= 2)}, 32'd1);

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      cycle(3'($urandom_range(0, 7)),
            int'($urandom_range(0, 2199)), int'($urandom_range(0, 2199)), int'($urandom_range(0, 2199)),
            int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
            ($urandom_range(0, 499) == 0), g);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
